execute_sequencer: RTL
======================

Name: execute_sequencer

Overview:
- Sequences the execution unit: accepts one decoded instruction at a time from decode, holds it until its source registers are free of pending writes, issues it, then tracks completion.
- Single-cycle ALU ops finish in one issue cycle; multi-cycle ops (MUL/DIV) occupy the unit for MULTI_CYCLE_LATENCY cycles.
- A per-register scoreboard blocks RAW hazards against outstanding writebacks.
- Sits between the decode stage and the execution unit / register-file read port.

Parameters:
- REG_ADDR_WIDTH, 5, register index width.
- NUM_REGS, 32, architectural registers; x0 is hardwired and never pending.
- MULTI_CYCLE_LATENCY, 4, execute cycles for multi-cycle ops; legal range 2..15.
- STALL_CNT_WIDTH, 16, width of the hazard-stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  sequencer can accept an instruction
- in_rd  in  REG_ADDR_WIDTH  destination register
- in_rs1  in  REG_ADDR_WIDTH  source 1
- in_rs2  in  REG_ADDR_WIDTH  source 2
- in_uses_rs1  in  1  instruction reads rs1
- in_uses_rs2  in  1  instruction reads rs2
- in_writes_rd  in  1  instruction writes rd
- in_multicycle  in  1  instruction is MUL/DIV class
- flush  in  1  discard held or in-flight instruction
- issue_valid  out  1  one-cycle pulse: execution unit operands valid; register file read occurs this cycle
- issue_rs1  out  REG_ADDR_WIDTH  held rs1 (register-file read address)
- issue_rs2  out  REG_ADDR_WIDTH  held rs2 (register-file read address)
- complete_valid  out  1  execution result ready for writeback
- complete_rd  out  REG_ADDR_WIDTH  destination of the completing instruction
- complete_writes_rd  out  1  completing instruction writes rd
- complete_ready  in  1  writeback accepts the result
- wb_valid  in  1  writeback committed a register
- wb_rd  in  REG_ADDR_WIDTH  register committed
- stall_count  out  STALL_CNT_WIDTH  saturating count of hazard-stall cycles

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset state:
  - state = IDLE; scoreboard all zero; stall_count = 0.
  - in_ready = 1, issue_valid = 0, complete_valid = 0.
  - complete_rd, complete_writes_rd, issue_rs1, issue_rs2 = 0.
- States: IDLE, HOLD, BUSY, COMPLETE.
- Outputs by state:
  - in_ready = 1 only in IDLE.
  - complete_valid = 1 only in COMPLETE.
  - issue_rs1/issue_rs2 come from the holding register, stable from HOLD through COMPLETE.
- IDLE: in_valid && in_ready latches all in_* fields into the holding register, then -> HOLD.
- HOLD:
  - hazard = (uses_rs1 && rs1!=0 && pending[rs1]) || (uses_rs2 && rs2!=0 && pending[rs2]), evaluated on the registered scoreboard.
  - Hazard: stay in HOLD; stall_count += 1, saturating at all-ones.
  - No hazard: issue_valid = 1 this cycle (combinational from state and scoreboard). If writes_rd && rd!=0, set pending[rd] at the clock edge.
  - After issue: single-cycle op -> COMPLETE; multi-cycle op -> BUSY with counter = MULTI_CYCLE_LATENCY-1.
- BUSY: counter decrements each cycle; when counter==1 -> COMPLETE. Multi-cycle op is therefore in BUSY for MULTI_CYCLE_LATENCY-1 cycles.
- COMPLETE: hold complete_* stable until complete_ready; on handshake -> IDLE. No new accept in the same cycle; back-to-back throughput is one instruction per 3 cycles minimum.
- Latency, with accept at edge T:
  - HOLD at T+1; issue at T+1 if no hazard.
  - Single-cycle: complete_valid at T+2.
  - Multi-cycle: complete_valid at T+1+MULTI_CYCLE_LATENCY.
- Scoreboard:
  - wb_valid && wb_rd!=0 clears pending[wb_rd] at the edge. A clear unblocks HOLD from the next cycle; there is no same-cycle bypass.
  - Issue set and wb clear to the same register in one cycle: set wins.
  - Register 0 is never set.
- flush:
  - In HOLD, BUSY or COMPLETE: next state IDLE; issue_valid forced 0 that cycle.
  - Any pending bit already set by the flushed instruction remains; writeback must not return it, so the owner of flush also drives a matching wb clear.
  - flush in IDLE also blocks acceptance that cycle (in_ready still reads 1, but the handshake is ignored).
- reset mid-operation: returns to the reset state from any state, clears the scoreboard, and discards the held instruction.

Test Plan:
- Single-cycle op: accept ADD rd=5 rs1=1 rs2=2 at T (scoreboard empty) -> issue_valid at T+1, complete_valid at T+2 with complete_rd=5; pending[5]=1 from T+2 until wb_valid wb_rd=5.
- RAW hazard: pending[3]=1; accept op with rs1=3 -> stays in HOLD, no issue_valid, stall_count increments each cycle. Pulse wb_valid wb_rd=3 at cycle C -> issue_valid at C+1, stall_count frozen.
- Multi-cycle op: MULTI_CYCLE_LATENCY=4, accept MUL at T -> issue at T+1, BUSY for 3 cycles, complete_valid at T+5. Hold complete_ready=0 for 2 cycles -> complete_valid and complete_rd stay stable; handshake -> in_ready=1 next cycle.
- Simultaneous set/clear, and x0:
  - Issue with rd=7 in the same cycle as wb_valid wb_rd=7 -> pending[7]=1 afterwards.
  - Issue with rd=0 -> no scoreboard change.
  - Op with rs1=0 and uses_rs1=1 -> never stalls.
- Flush/reset: flush during BUSY -> IDLE next cycle, complete_valid never asserts. Reset asserted during COMPLETE -> all outputs at reset values next cycle, scoreboard clear, stall_count=0.

Source files
------------

// File: rtl/execute_sequencer.sv
// Execute-stage sequencer: holds one decoded instruction, waits out RAW hazards
// against a per-register pending-write scoreboard, issues it, then presents completion.
module execute_sequencer #(
  parameter int REG_ADDR_WIDTH      = 5,
  parameter int NUM_REGS            = 32,
  parameter int MULTI_CYCLE_LATENCY = 4,
  parameter int STALL_CNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_ADDR_WIDTH-1:0]  in_rd,
  input  logic [REG_ADDR_WIDTH-1:0]  in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]  in_rs2,
  input  logic                       in_uses_rs1,
  input  logic                       in_uses_rs2,
  input  logic                       in_writes_rd,
  input  logic                       in_multicycle,
  input  logic                       flush,
  output logic                       issue_valid,
  output logic [REG_ADDR_WIDTH-1:0]  issue_rs1,
  output logic [REG_ADDR_WIDTH-1:0]  issue_rs2,
  output logic                       complete_valid,
  output logic [REG_ADDR_WIDTH-1:0]  complete_rd,
  output logic                       complete_writes_rd,
  input  logic                       complete_ready,
  input  logic                       wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  wb_rd,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic                      uses_rs1;
    logic                      uses_rs2;
    logic                      writes_rd;
    logic                      multicycle;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    BUSY     = 2'd2,
    COMPLETE = 2'd3
  } state_t;

  state_t                state, state_nxt;
  instr_t                held;
  logic [NUM_REGS-1:0]   pending;
  logic [3:0]            busy_cnt;
  logic                  accept;
  logic                  stall_inc;
  logic                  hazard;
  logic                  rs1_hit, rs2_hit;

  // Hazard uses the registered scoreboard only: a writeback clear is visible next cycle.
  assign rs1_hit = held.uses_rs1 && (held.rs1 != '0) && pending[held.rs1];
  assign rs2_hit = held.uses_rs2 && (held.rs2 != '0) && pending[held.rs2];
  assign hazard  = rs1_hit || rs2_hit;

  always_comb begin
    state_nxt      = state;
    in_ready       = 1'b0;
    issue_valid    = 1'b0;
    complete_valid = 1'b0;
    accept         = 1'b0;
    stall_inc      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (hazard) begin
          stall_inc = 1'b1;
        end else begin
          issue_valid = 1'b1;
          state_nxt   = held.multicycle ? BUSY : COMPLETE;
        end
      end
      BUSY: begin
        if (flush)               state_nxt = IDLE;
        else if (busy_cnt == 4'd1) state_nxt = COMPLETE;
      end
      COMPLETE: begin
        complete_valid = 1'b1;
        if (flush || complete_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)       held <= '0;
    else if (accept) held <= '{rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                               uses_rs1: in_uses_rs1, uses_rs2: in_uses_rs2,
                               writes_rd: in_writes_rd, multicycle: in_multicycle};
  end

  // Loaded at issue so that BUSY lasts MULTI_CYCLE_LATENCY-1 cycles.
  always_ff @(posedge clk) begin
    if (reset)                               busy_cnt <= '0;
    else if (issue_valid && held.multicycle) busy_cnt <= 4'(MULTI_CYCLE_LATENCY - 1);
    else if (state == BUSY)                  busy_cnt <= busy_cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)                           stall_count <= '0;
    else if (stall_inc && !(&stall_count)) stall_count <= stall_count + 1'b1;
  end

  // Scoreboard: x0 is never pending; an issue set beats a same-cycle writeback clear.
  assign pending[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic set_hit, clr_hit;
    assign set_hit = issue_valid && held.writes_rd && (held.rd == REG_ADDR_WIDTH'(r));
    assign clr_hit = wb_valid && (wb_rd == REG_ADDR_WIDTH'(r));
    always_ff @(posedge clk) begin
      if (reset)        pending[r] <= 1'b0;
      else if (set_hit) pending[r] <= 1'b1;
      else if (clr_hit) pending[r] <= 1'b0;
    end
  end

  assign issue_rs1          = held.rs1;
  assign issue_rs2          = held.rs2;
  assign complete_rd        = held.rd;
  assign complete_writes_rd = held.writes_rd;

endmodule
